// File: rtl/icache_assoc_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// Geometry-dependent widths live in the modules, derived from their parameters.
package icache_assoc_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        ICHECK = 2'd0,
        IFILL  = 2'd1,
        IINVAL = 2'd2
    } iastate_t;

endpackage

// File: rtl/icache_assoc_plru_tree.sv
// Tree pseudo-LRU for one set: given its bits and the way just used, return the
// bits pointing away from that way plus the way the current bits nominate as victim.
module plru_tree #(
    parameter  int WAYS   = 2,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] bits_in,
    input  logic [WAY_W-1:0]  acc_way,
    output logic [PLRU_W-1:0] bits_out,
    output logic [WAY_W-1:0]  victim
);

    generate
        if (WAYS == 4) begin : g_four
            // bit0 is the root (0: pair {0,1}, 1: pair {2,3}); bit1/bit2 choose inside a pair
            always_comb begin
                bits_out    = bits_in;
                bits_out[0] = ~acc_way[1];
                if (acc_way[1])
                    bits_out[2] = ~acc_way[0];
                else
                    bits_out[1] = ~acc_way[0];
                victim = bits_in[0] ? {1'b1, bits_in[2]} : {1'b0, bits_in[1]};
            end
        end else if (WAYS == 2) begin : g_two
            assign bits_out = ~acc_way;
            assign victim   = bits_in;
        end else begin : g_one
            logic unused_in;
            assign unused_in = ^{bits_in, acc_way};
            assign bits_out  = '0;
            assign victim    = '0;
        end
    endgenerate

endmodule

// File: rtl/icache_assoc.sv
// Read-only set-associative instruction cache with register storage, tree PLRU,
// whole-cache invalidate sweep and saturating hit/miss counters.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inv,
    output logic        inv_busy,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF_W  = $clog2(BLKWORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = WORD_W - BYTE_OFF_W - OFF_W - IDX_W;
    localparam int CNT_W  = (BLKWORDS > 1) ? OFF_W : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    iastate_t state;

    logic [SETS-1:0][WAYS-1:0]                          valid;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]               tags;
    logic [SETS-1:0][WAYS-1:0][BLKWORDS-1:0][WORD_W-1:0] data;
    logic [SETS-1:0][PLRU_W-1:0]                        plru;

    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [WAY_W-1:0] fill_way;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] inv_idx;
    logic             inv_pend;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [CNT_W-1:0] req_off;
    logic [31:0]      fill_addr;
    logic             unused_byte;

    assign req_tag     = imemaddr[31 -: TAG_W];
    assign req_idx     = imemaddr[BYTE_OFF_W + OFF_W +: IDX_W];
    assign unused_byte = ^imemaddr[BYTE_OFF_W-1:0];

    generate
        if (BLKWORDS > 1) begin : g_multi
            assign req_off   = imemaddr[BYTE_OFF_W +: OFF_W];
            assign fill_addr = {fill_tag, fill_idx, cnt, {BYTE_OFF_W{1'b0}}};
        end else begin : g_single
            assign req_off   = '0;
            assign fill_addr = {fill_tag, fill_idx, {BYTE_OFF_W{1'b0}}};
        end
    endgenerate

    // Lookup: a pending invalidate turns the ICHECK cycle into a pure transition.
    logic [WAYS-1:0]  match;
    logic [WAY_W-1:0] hit_way;
    logic             lookup, miss, last_word;

    for (genvar w = 0; w < WAYS; w++) begin : g_match
        assign match[w] = valid[req_idx][w] && (tags[req_idx][w] == req_tag);
    end

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (match[w]) hit_way = WAY_W'(w);
    end

    assign lookup    = (state == ICHECK) && !inv_pend && imemREN;
    assign ihit      = lookup && (|match);
    assign miss      = lookup && !(|match);
    assign imemload  = ihit ? data[req_idx][hit_way][req_off] : '0;
    assign iREN      = (state == IFILL);
    assign iaddr     = iREN ? fill_addr : '0;
    assign inv_busy  = inv_pend || (state == IINVAL);
    assign last_word = (cnt == CNT_W'(BLKWORDS - 1));

    // One PLRU evaluator, shared: hit update in ICHECK, fill completion in IFILL.
    logic [IDX_W-1:0]  plru_idx;
    logic [WAY_W-1:0]  acc_way, plru_victim, victim;
    logic [PLRU_W-1:0] plru_next;

    assign plru_idx = (state == IFILL) ? fill_idx : req_idx;
    assign acc_way  = (state == IFILL) ? fill_way : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_in  (plru[plru_idx]),
        .acc_way  (acc_way),
        .bits_out (plru_next),
        .victim   (plru_victim)
    );

    always_comb begin
        victim = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[req_idx][w]) victim = WAY_W'(w);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ICHECK;
            valid    <= '0;
            plru     <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            cnt      <= '0;
            inv_pend <= 1'b0;
            inv_idx  <= '0;
            fill_tag <= '0;
            fill_idx <= '0;
            fill_way <= '0;
        end else begin
            if (inv) inv_pend <= 1'b1;
            case (state)
                ICHECK: begin
                    if (inv_pend) begin
                        // pending is consumed here; a pulse during the sweep re-arms it
                        inv_pend <= inv;
                        inv_idx  <= '0;
                        state    <= IINVAL;
                    end else if (ihit) begin
                        plru[req_idx] <= plru_next;
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                    end else if (miss) begin
                        fill_tag <= req_tag;
                        fill_idx <= req_idx;
                        fill_way <= victim;
                        cnt      <= '0;
                        state    <= IFILL;
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                    end
                end
                IFILL: begin
                    if (!iwait) begin
                        valid[fill_idx][fill_way] <= 1'b0;
                        if (last_word) begin
                            valid[fill_idx][fill_way] <= 1'b1;
                            plru[fill_idx]            <= plru_next;
                            cnt                       <= '0;
                            state                     <= ICHECK;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                IINVAL: begin
                    valid[inv_idx] <= '0;
                    plru[inv_idx]  <= '0;
                    if (inv_idx == IDX_W'(SETS - 1))
                        state <= ICHECK;
                    else
                        inv_idx <= inv_idx + IDX_W'(1);
                end
                default: state <= ICHECK;
            endcase
        end
    end

    // Payload storage needs no reset: nothing is read until its valid bit is set.
    always_ff @(posedge CLK) begin
        if (state == IFILL && !iwait) begin
            data[fill_idx][fill_way][cnt] <= iload;
            if (last_word) tags[fill_idx][fill_way] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc (SETS=8, WAYS=2, BLKWORDS=2): directed scenarios with literal
// expectations plus random traffic checked every cycle against an LRU-based cache model.
module tb_icache_assoc;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        inv = 1'b0;
    logic        iwait = 1'b0;
    logic [31:0] iload;
    logic        ihit, inv_busy, iREN;
    logic [31:0] imemload, iaddr, hit_cnt, miss_cnt;

    int vecs = 0;
    int errs = 0;

    icache_assoc dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inv(inv), .inv_busy(inv_busy),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'hAAAA0001;
        if (a == 32'h44) return 32'hAAAA0002;
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign iload = memf(iaddr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 8 sets x 2 ways; with two ways tree PLRU equals true LRU, tracked as the MRU way.
    int          m_mode;   // 0 lookup, 1 filling, 2 sweeping
    bit          m_pend;
    bit          mv[8][2];
    logic [25:0] mt[8][2];
    logic [31:0] md[8][2][2];
    int          m_mru[8];
    logic [25:0] m_ftag;
    int          m_fidx, m_fway, m_fcnt, m_iidx;
    logic [31:0] m_hc, m_mc;

    function automatic logic [31:0] faddr();
        return (32'(m_ftag) << 6) | (32'(m_fidx) << 3) | (32'(m_fcnt) << 2);
    endfunction

    task automatic m_reset();
        m_mode = 0; m_pend = 0; m_hc = 0; m_mc = 0; m_fcnt = 0; m_iidx = 0;
        for (int s = 0; s < 8; s++) begin
            mv[s][0] = 0; mv[s][1] = 0; m_mru[s] = 1;
        end
    endtask

    initial m_reset();

    always @(negedge CLK) begin : model
        logic [25:0] tg;
        int  ix, of, ew;
        bit  eh, np;
        if (RST) begin
            chk("rst_ihit", ihit, 0);
            chk("rst_imemload", imemload, 0);
            chk("rst_iREN", iREN, 0);
            chk("rst_iaddr", iaddr, 0);
            chk("rst_inv_busy", inv_busy, 0);
            chk("rst_hit_cnt", hit_cnt, 0);
            chk("rst_miss_cnt", miss_cnt, 0);
            m_reset();
        end else begin
            tg = imemaddr[31:6];
            ix = int'(imemaddr[5:3]);
            of = int'(imemaddr[2]);
            eh = 0; ew = 0;
            if (m_mode == 0 && !m_pend && imemREN)
                for (int w = 0; w < 2; w++)
                    if (mv[ix][w] && mt[ix][w] == tg) begin eh = 1; ew = w; end
            chk("m_ihit", ihit, eh);
            if (eh) chk("m_imemload", imemload, md[ix][ew][of]);
            chk("m_iREN", iREN, m_mode == 1);
            if (m_mode == 1) chk("m_iaddr", iaddr, faddr());
            chk("m_inv_busy", inv_busy, m_pend || m_mode == 2);
            chk("m_hit_cnt", hit_cnt, m_hc);
            chk("m_miss_cnt", miss_cnt, m_mc);

            np = m_pend | inv;
            case (m_mode)
                0: begin
                    if (m_pend) begin
                        m_mode = 2; m_iidx = 0; np = inv;
                    end else if (eh) begin
                        m_mru[ix] = ew;
                        if (m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
                    end else if (imemREN) begin
                        m_ftag = tg; m_fidx = ix; m_fcnt = 0; m_mode = 1;
                        m_fway = !mv[ix][0] ? 0 : (!mv[ix][1] ? 1 : 1 - m_mru[ix]);
                        if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
                    end
                end
                1: if (!iwait) begin
                    md[m_fidx][m_fway][m_fcnt] = memf(faddr());
                    mv[m_fidx][m_fway] = 0;
                    if (m_fcnt == 1) begin
                        mv[m_fidx][m_fway] = 1;
                        mt[m_fidx][m_fway] = m_ftag;
                        m_mru[m_fidx] = m_fway;
                        m_fcnt = 0; m_mode = 0;
                    end else begin
                        m_fcnt++;
                    end
                end
                default: begin
                    mv[m_iidx][0] = 0; mv[m_iidx][1] = 0; m_mru[m_iidx] = 1;
                    if (m_iidx == 7) m_mode = 0; else m_iidx++;
                end
            endcase
            m_pend = np;
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Request a word and return how many cycles passed before ihit; consumes the hit edge.
    task automatic fetch(input logic [31:0] a, output int lat);
        imemaddr = a; imemREN = 1'b1; #1;
        lat = 0;
        while (ihit !== 1'b1 && lat < 40) begin
            @(posedge CLK); #2; lat++;
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        int n;
        #1 RST = 1'b1;
        #2;
        chk("reset_iREN", iREN, 0);
        chk("reset_hit_cnt", hit_cnt, 0);
        chk("reset_miss_cnt", miss_cnt, 0);
        chk("reset_inv_busy", inv_busy, 0);
        tick(); tick();

        // cold miss, then neighbouring word of the same block
        RST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
        #1 chk("cold_no_hit", ihit, 0); chk("cold_no_iREN", iREN, 0);
        tick(); #1 chk("cold_iREN", iREN, 1); chk("cold_iaddr0", iaddr, 32'h40);
        tick(); #1 chk("cold_iaddr1", iaddr, 32'h44);
        tick(); #1 chk("cold_hit", ihit, 1); chk("cold_data", imemload, 32'hAAAA0001);
        chk("cold_miss_cnt", miss_cnt, 1);
        tick(); imemaddr = 32'h44;
        #1 chk("next_hit", ihit, 1); chk("next_data", imemload, 32'hAAAA0002);
        chk("next_hit_cnt", hit_cnt, 1);

        // same fill with 3 stall cycles per word
        tick(); RST = 1'b1;
        tick(); RST = 1'b0; imemaddr = 32'h40; iwait = 1'b1;
        #1 chk("stall_no_hit0", ihit, 0);
        tick();
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 4; k++) begin
                iwait = (k < 3);
                #1 chk("stall_iaddr", iaddr, 32'h40 + 32'(4 * w));
                chk("stall_no_hit", ihit, 0);
                tick();
            end
        #1 chk("stall_hit", ihit, 1); chk("stall_data", imemload, 32'hAAAA0001);
        tick();

        // conflict in set 0: 0xC0 must displace the least recently used 0x80
        fetch(32'h80, n); chk("lru_0x80_miss", n, 3);
        fetch(32'h40, n); chk("lru_0x40_hit", n, 0);
        fetch(32'hC0, n); chk("lru_0xC0_miss", n, 3);
        fetch(32'h40, n); chk("lru_0x40_kept", n, 0);
        fetch(32'h80, n); chk("lru_0x80_evicted", n, 3);

        // whole-cache invalidate
        fetch(32'h40, n); chk("inv_pre_hit", n, 0);
        imemREN = 1'b0; inv = 1'b1;
        tick(); inv = 1'b0;
        #1 n = 0;
        while (inv_busy === 1'b1 && n < 40) begin n++; @(posedge CLK); #2; end
        chk("inv_busy_cycles", n, 9);
        fetch(32'h40, n); chk("inv_then_miss", n, 3);

        // invalidate requested on the last word of a fill
        imemaddr = 32'h80; imemREN = 1'b1;
        tick(); tick(); inv = 1'b1;
        #1 chk("invfill_iREN", iREN, 1); chk("invfill_iaddr", iaddr, 32'h84);
        tick(); inv = 1'b0;
        #1 chk("invfill_no_hit", ihit, 0); chk("invfill_busy", inv_busy, 1);
        imemREN = 1'b0; n = 0;
        while (inv_busy === 1'b1 && n < 40) begin n++; @(posedge CLK); #2; end
        chk("invfill_busy_cycles", n, 9);
        fetch(32'h40, n); chk("invfill_then_miss", n, 3);

        // reset in the middle of a fill
        imemaddr = 32'hC0;
        tick(); #1 chk("rstfill_iREN_before", iREN, 1);
        RST = 1'b1;
        #1 chk("rstfill_iREN", iREN, 0); chk("rstfill_hit_cnt", hit_cnt, 0);
        chk("rstfill_miss_cnt", miss_cnt, 0);
        @(posedge CLK); #1 RST = 1'b0;
        fetch(32'h40, n); chk("rstfill_then_miss", n, 3);

        // random traffic concentrated on a few sets and tags
        for (int c = 0; c < 2500; c++) begin
            imemREN = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) != 0) begin
                imemaddr = {23'(0), 3'($urandom_range(0, 5)), 6'h0};
                imemaddr[5:3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                            : 3'($urandom_range(0, 1));
                imemaddr[2:0] = 3'($urandom_range(0, 7));
            end
            iwait = ($urandom_range(0, 9) < 3);
            inv   = ($urandom_range(0, 99) < 2);
            tick();
        end
        imemREN = 1'b0; inv = 1'b0; iwait = 1'b0;
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
